dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe_pkg.sv | 11 +
 rtl/dff_pipe_stage.sv | 32 +++
 rtl/dff_pipe.sv | 100 ++++++++++
 tb/tb_dff_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe valid/ready register pipeline.
package dff_pipe_pkg;

  localparam int DEPTH_MAX = 16;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One WIDTH-bit data+valid pipeline stage with load/hold and synchronous valid clear.
module dff_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= up_valid;
      end
      // Bubbles move only the valid bit; data stays put so idle stages don't toggle.
      if (load && up_valid && !clear) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with per-stage valids and bubble collapse.
// Optional occupancy counter and occ port when DFF_PIPE_OCC_EN is defined.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] up_data    [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] adv;

  // Advance ripples from the output back to the input in one combinational pass.
  always_comb begin : adv_chain
    logic downstream;
    adv        = '0;
    downstream = q_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]     = en & (~stage_valid[i] | downstream);
      downstream = adv[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign up_data[gi]  = d;
        assign up_valid[gi] = d_valid;
      end else begin : g_body
        assign up_data[gi]  = stage_data[gi-1];
        assign up_valid[gi] = stage_valid[gi-1];
      end

      dff_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (adv[gi]),
        .clear    (flush),
        .up_data  (up_data[gi]),
        .up_valid (up_valid[gi]),
        .data     (stage_data[gi]),
        .valid    (stage_valid[gi])
      );
    end
  endgenerate

  assign d_ready = adv[0];
  assign q       = stage_data[DEPTH-1];
  assign q_valid = stage_valid[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_reg;
  logic             accept;
  logic             emit;

  assign accept = adv[0] & d_valid;
  assign emit   = adv[DEPTH-1] & stage_valid[DEPTH-1];

  // Tracks popcount(stage_valid) incrementally instead of summing the vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else if (flush) begin
      occ_reg <= '0;
    end else begin
      case ({accept, emit})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign occ = occ_reg;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=3); occ checked when DFF_PIPE_OCC_EN is set.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             d_valid = 1'b0;
  logic             d_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready = 1'b1;
`ifdef DFF_PIPE_OCC_EN
  logic [1:0]       occ;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  dff_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .flush   (flush),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ     (occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic check_occ(input string tag, input int exp);
`ifdef DFF_PIPE_OCC_EN
    check(tag, 32'(occ), 32'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    d       = v;
    d_valid = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_valid", 32'(q_valid), 32'h0);
    check_occ("rst_occ", 0);
    #5 rst_n = 1'b1;
    tick();

    // Streaming 0x11,0x22,0x33, q_ready=1
    push(8'h11);
    check("stream_e1_qv", 32'(q_valid), 32'h0);
    push(8'h22);
    check("stream_e2_qv", 32'(q_valid), 32'h0);
    push(8'h33);
    check("stream_q0", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h11});
    d_valid = 1'b0;
    tick();
    check("stream_q1", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h22});
    tick();
    check("stream_q2", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h33});
    tick();
    check("stream_drain_qv", 32'(q_valid), 32'h0);

    // en=0 freezes a pipe holding one word at the output
    push(8'h5A);
    d_valid = 1'b0;
    tick();
    tick();
    q_ready = 1'b0;
    check("frz_pre_q", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h5A});
    en = 1'b0; d = 8'hAA; d_valid = 1'b1; q_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("frz_d_ready%0d", i), 32'(d_ready), 32'h0);
      tick();
      check($sformatf("frz_q%0d", i), {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h5A});
      check_occ($sformatf("frz_occ%0d", i), 1);
    end
    en = 1'b1; d_valid = 1'b0;
    tick();
    check("frz_release_qv", 32'(q_valid), 32'h0);

    // Backpressure: q_ready=0, push 0x01..0x04
    q_ready = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    d = 8'h04; d_valid = 1'b1;
    #1;
    check("bp_full_d_ready", 32'(d_ready), 32'h0);
    check_occ("bp_full_occ", 3);
    tick();
    check("bp_hold_q", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h01});
    q_ready = 1'b1;
    #1;
    check("bp_release_d_ready", 32'(d_ready), 32'h1);
    tick();
    d_valid = 1'b0;
    check("bp_out2", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h02});
    tick();
    check("bp_out3", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h03});
    tick();
    check("bp_out4", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h04});
    tick();
    check("bp_empty_qv", 32'(q_valid), 32'h0);

    // Bubble collapse: 0x55, idle, 0x66 with q_ready=0
    q_ready = 1'b0;
    push(8'h55);
    d_valid = 1'b0;
    tick();
    push(8'h66);
    d_valid = 1'b0;
    tick();
    tick();
    check("bub_q", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'h55});
    check("bub_d_ready", 32'(d_ready), 32'h1);
    check_occ("bub_occ", 2);

    // Flush with q_ready=1 while two words are held
    q_ready = 1'b1; flush = 1'b1;
    #1;
    check("fl_d_ready", 32'(d_ready), 32'h1);
    tick();
    flush = 1'b0;
    check("fl_qv", 32'(q_valid), 32'h0);
    check_occ("fl_occ", 0);
    tick();
    tick();
    check("fl_no_dup_qv", 32'(q_valid), 32'h0);

    // Async reset between edges with a full pipe
    q_ready = 1'b0;
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    d_valid = 1'b0;
    check("ar_pre_q", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'hA1});
    #2 rst_n = 1'b0;
    #1;
    check("ar_q", 32'(q), 32'h0);
    check("ar_qv", 32'(q_valid), 32'h0);
    check_occ("ar_occ", 0);
    @(negedge clk);
    rst_n = 1'b1;
    q_ready = 1'b1;
    push(8'hB7);
    d_valid = 1'b0;
    tick();
    check("ar_after_qv", 32'(q_valid), 32'h0);
    tick();
    check("ar_after_q", {23'h0, q_valid, q}, {23'h0, 1'b1, 8'hB7});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
